spi_txn_sequencer: RTL and testbench

SPI_TXN_SEQUENCER -- requirements
Module: spi_txn_sequencer

---
 rtl/spi_txn_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer.sv
// Command FIFO plus launch/response sequencer sitting between a host and an SPI master.
// Each queued command is issued as one txn_en pulse and answered by exactly one response.
module spi_txn_sequencer #(
  parameter int unsigned SLAVE_COUNT   = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned START_TIMEOUT = 8,
  localparam int unsigned AW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [1:0]    cmd_len,
  input  logic [1:0]    cmd_mode,
  input  logic [31:0]   cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_err,
  output logic          txn_en,
  input  logic          busy_m,
  output logic [AW-1:0] s_addr,
  output logic [1:0]    txn_len,
  output logic [1:0]    spi_mode,
  output logic [31:0]   tx_data_m,
  input  logic [31:0]   rx_data_m
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic [1:0]    mode;
    logic [31:0]   data;
  } cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StRespond
  } state_e;

  // ---------------------------------------------------------------- command FIFO
  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;
  cmd_t          head;

  state_e        state_q, state_d;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // Pop coincides with the IDLE -> LAUNCH edge; the head is captured on the same edge.
  assign pop       = (state_q == StIdle) && !empty && !busy_m;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: cmd_addr, len: cmd_len, mode: cmd_mode, data: cmd_data};
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------- sequencer FSM
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          txn_en_q, txn_en_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [1:0]    txn_len_q, txn_len_d;
  logic [1:0]    spi_mode_q, spi_mode_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [AW-1:0] rsp_addr_q, rsp_addr_d;
  logic          rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    txn_en_d    = 1'b0;
    s_addr_d    = s_addr_q;
    txn_len_d   = txn_len_q;
    spi_mode_d  = spi_mode_q;
    tx_data_d   = tx_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d    = StLaunch;
          txn_en_d   = 1'b1;
          s_addr_d   = head.addr;
          txn_len_d  = head.len;
          spi_mode_d = head.mode;
          tx_data_d  = head.data;
        end
      end
      StLaunch: begin
        state_d   = StWaitBusy;
        tmo_cnt_d = '0;
      end
      StWaitBusy: begin
        if (busy_m) begin
          state_d = StWaitDone;
        end else if (tmo_cnt_q == TW'(START_TIMEOUT - 1)) begin
          // Counter reaches START_TIMEOUT on this edge: master never started.
          state_d     = StRespond;
          tmo_cnt_d   = TW'(START_TIMEOUT);
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          rsp_addr_d  = s_addr_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      StWaitDone: begin
        if (!busy_m) begin
          state_d     = StRespond;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = rx_data_m;
          rsp_addr_d  = s_addr_q;
        end
      end
      StRespond: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      txn_en_q    <= 1'b0;
      s_addr_q    <= '0;
      txn_len_q   <= '0;
      spi_mode_q  <= '0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      txn_en_q    <= txn_en_d;
      s_addr_q    <= s_addr_d;
      txn_len_q   <= txn_len_d;
      spi_mode_q  <= spi_mode_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign txn_en    = txn_en_q;
  assign s_addr    = s_addr_q;
  assign txn_len   = txn_len_q;
  assign spi_mode  = spi_mode_q;
  assign tx_data_m = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Bench for spi_txn_sequencer: queue-based command/response model, a simple SPI master
// model and directed scenarios with literal expectations.
module tb_spi_txn_sequencer;

  localparam int SLAVE_COUNT   = 4;
  localparam int FIFO_DEPTH    = 4;
  localparam int START_TIMEOUT = 8;
  localparam int AW            = 2;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_len, cmd_mode;
  logic [31:0]   cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          txn_en, busy_m;
  logic [AW-1:0] s_addr;
  logic [1:0]    txn_len, spi_mode;
  logic [31:0]   tx_data_m, rx_data_m;

  always #5 sys_clk = ~sys_clk;

  spi_txn_sequencer #(
    .SLAVE_COUNT  (SLAVE_COUNT),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_mode (cmd_mode),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_addr (rsp_addr),
    .rsp_err  (rsp_err),
    .txn_en   (txn_en),
    .busy_m   (busy_m),
    .s_addr   (s_addr),
    .txn_len  (txn_len),
    .spi_mode (spi_mode),
    .tx_data_m(tx_data_m),
    .rx_data_m(rx_data_m)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic [1:0]    mode;
    logic [31:0]   data;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          err;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    chk(act === req, name, act, req);
  endtask

  function automatic logic [31:0] rx_fn(input logic [31:0] d);
    return {d[15:0], d[31:16]} ^ 32'h5A5A_0000;
  endfunction

  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- SPI master model
  bit          no_busy   = 1'b0;
  int          busy_len  = 4;
  bit          rx_ovr_en = 1'b0;
  logic [31:0] rx_ovr    = '0;

  initial begin
    busy_m    = 1'b0;
    rx_data_m = '0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (txn_en && !rst && !no_busy) begin
        busy_m = 1'b1;
        repeat (busy_len) @(posedge sys_clk);
        #2;
        rx_data_m = rx_ovr_en ? rx_ovr : rx_fn(tx_data_m);
        busy_m    = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- reference model / compare
  cmd_t        pend[$];
  rsp_t        exp_q[$];
  cmd_t        c_tmp, launched;
  rsp_t        e_tmp, held;
  bit          prev_hs, prev_txn, prev_rv, inflight, hs_now;
  int          launch_cyc;
  int          txn_cnt = 0;
  int          hs_cnt  = 0;
  logic [31:0] last_data;
  logic [AW-1:0] last_addr;
  logic        last_err;

  always @(negedge sys_clk) begin
    if (rst) begin
      chk_eq("reset_ctrl", 32'({cmd_ready, rsp_valid, rsp_err, txn_en, s_addr, rsp_addr,
                                txn_len, spi_mode}), 32'h800);
      chk_eq("reset_data", rsp_data | tx_data_m, 32'h0);
      pend.delete();
      exp_q.delete();
      prev_hs  = 1'b0;
      prev_txn = 1'b0;
      prev_rv  = 1'b0;
      inflight = 1'b0;
    end else begin
      hs_now = 1'b0;
      if (prev_hs) begin
        chk_eq("rsp_valid_drop", 32'(rsp_valid), 32'h0);
        chk_eq("no_launch_at_handshake", 32'(txn_en), 32'h0);
      end
      if (prev_rv && !prev_hs) begin
        chk_eq("rsp_valid_hold", 32'(rsp_valid), 32'h1);
        chk_eq("rsp_data_hold", rsp_data, held.data);
        chk_eq("rsp_meta_hold", 32'({rsp_addr, rsp_err}), 32'({held.addr, held.err}));
      end
      if (rsp_valid && !prev_rv && exp_q.size() != 0 && exp_q[0].err) begin
        chk_eq("timeout_latency", 32'(cyc - launch_cyc), 32'(START_TIMEOUT + 1));
      end
      if (txn_en) begin
        txn_cnt++;
        chk_eq("txn_en_single_cycle", 32'(prev_txn), 32'h0);
        chk_eq("launch_while_rsp_valid", 32'(rsp_valid), 32'h0);
        chk(pend.size() != 0, "launch_without_cmd", 32'(pend.size()), 32'h1);
        if (pend.size() != 0) begin
          c_tmp = pend.pop_front();
          chk_eq("launch_addr", 32'(s_addr), 32'(c_tmp.addr));
          chk_eq("launch_len_mode", 32'({txn_len, spi_mode}), 32'({c_tmp.len, c_tmp.mode}));
          chk_eq("launch_data", tx_data_m, c_tmp.data);
          launched   = c_tmp;
          inflight   = 1'b1;
          launch_cyc = cyc;
          e_tmp.addr = c_tmp.addr;
          e_tmp.err  = no_busy;
          e_tmp.data = no_busy ? 32'h0 : (rx_ovr_en ? rx_ovr : rx_fn(c_tmp.data));
          exp_q.push_back(e_tmp);
        end
      end else if (inflight) begin
        chk_eq("hold_addr_len_mode", 32'({s_addr, txn_len, spi_mode}),
               32'({launched.addr, launched.len, launched.mode}));
        chk_eq("hold_tx_data", tx_data_m, launched.data);
      end
      chk_eq("cmd_ready", 32'(cmd_ready), 32'(pend.size() < FIFO_DEPTH));
      if (rsp_valid && rsp_ready) begin
        hs_cnt++;
        hs_now = 1'b1;
        chk(exp_q.size() != 0, "unexpected_response", 32'(exp_q.size()), 32'h1);
        if (exp_q.size() != 0) begin
          e_tmp = exp_q.pop_front();
          chk_eq("rsp_data", rsp_data, e_tmp.data);
          chk_eq("rsp_addr", 32'(rsp_addr), 32'(e_tmp.addr));
          chk_eq("rsp_err", 32'(rsp_err), 32'(e_tmp.err));
        end
        last_data = rsp_data;
        last_addr = rsp_addr;
        last_err  = rsp_err;
        inflight  = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        c_tmp.addr = cmd_addr;
        c_tmp.len  = cmd_len;
        c_tmp.mode = cmd_mode;
        c_tmp.data = cmd_data;
        pend.push_back(c_tmp);
      end
      prev_hs   = hs_now;
      prev_txn  = txn_en;
      prev_rv   = rsp_valid;
      held.data = rsp_data;
      held.addr = rsp_addr;
      held.err  = rsp_err;
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic push(input logic [AW-1:0] a, input logic [1:0] l, input logic [1:0] m,
                      input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_mode  = m;
    cmd_data  = d;
    while (!cmd_ready && n < 300) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk(n < 300, "push_accept_bound", 32'(n), 32'd300);
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((pend.size() != 0 || exp_q.size() != 0 || busy_m) && n < 2000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk(n < 2000, "drain_bound", 32'(n), 32'd2000);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_busy(input bit level, input string name);
    int n = 0;
    while (busy_m !== level && n < 100) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk(n < 100, name, 32'(n), 32'd100);
  endtask

  // ---------------------------------------------------------------- directed scenarios
  int base_txn, base_hs;

  initial begin
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_mode  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk_eq("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    chk_eq("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    @(posedge sys_clk);
    #1;

    // Single 8-bit command, master returns 0x3C.
    rx_ovr_en = 1'b1;
    rx_ovr    = 32'h0000_003C;
    busy_len  = 4;
    base_txn  = txn_cnt;
    base_hs   = hs_cnt;
    push(2'd2, 2'b00, 2'b01, 32'h0000_00A5);
    @(posedge sys_clk);
    #1;
    chk_eq("t1_latency_txn_en", 32'(txn_en), 32'h1);
    chk_eq("t1_s_addr", 32'(s_addr), 32'h2);
    wait_drain();
    chk_eq("t1_rsp_data", last_data, 32'h0000_003C);
    chk_eq("t1_rsp_addr", 32'(last_addr), 32'h2);
    chk_eq("t1_rsp_err", 32'(last_err), 32'h0);
    chk_eq("t1_txn_pulses", 32'(txn_cnt - base_txn), 32'h1);
    chk_eq("t1_responses", 32'(hs_cnt - base_hs), 32'h1);
    rx_ovr_en = 1'b0;

    // 32-bit, mode 11: launch fields held while busy.
    busy_len = 6;
    push(2'd1, 2'b11, 2'b11, 32'hDEAD_BEEF);
    wait_busy(1'b1, "t2_busy_seen");
    repeat (5) begin
      chk_eq("t2_txn_len", 32'(txn_len), 32'h3);
      chk_eq("t2_tx_data", tx_data_m, 32'hDEAD_BEEF);
      @(posedge sys_clk);
      #1;
    end
    wait_drain();

    // Fill the FIFO behind a long transaction.
    busy_len = 30;
    base_hs  = hs_cnt;
    push(2'd0, 2'b00, 2'b00, 32'h0000_0011);
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      push(AW'(i), 2'(i), 2'(i + 1), 32'h100 + 32'(i));
    end
    chk_eq("t3_full_cmd_ready", 32'(cmd_ready), 32'h0);
    push(2'd1, 2'b01, 2'b10, 32'h0000_0999);
    wait_drain();
    chk_eq("t3_responses", 32'(hs_cnt - base_hs), 32'd6);

    // Start timeout, then a normal command.
    busy_len = 3;
    no_busy  = 1'b1;
    push(2'd3, 2'b01, 2'b00, 32'h0000_0077);
    wait_drain();
    chk_eq("t4_to_err", 32'(last_err), 32'h1);
    chk_eq("t4_to_data", last_data, 32'h0);
    chk_eq("t4_to_addr", 32'(last_addr), 32'h3);
    no_busy = 1'b0;
    push(2'd0, 2'b10, 2'b01, 32'h1234_5678);
    wait_drain();
    chk_eq("t4_next_data", last_data, 32'h0C22_1234);
    chk_eq("t4_next_err", 32'(last_err), 32'h0);

    // Response back-pressure with a second command queued.
    rsp_ready = 1'b0;
    base_txn  = txn_cnt;
    push(2'd1, 2'b00, 2'b10, 32'h0000_000A);
    push(2'd2, 2'b01, 2'b11, 32'h0000_000B);
    begin
      int n = 0;
      while (!rsp_valid && n < 100) begin
        @(posedge sys_clk);
        #1;
        n++;
      end
      chk(n < 100, "t5_rsp_valid_bound", 32'(n), 32'd100);
    end
    repeat (20) @(posedge sys_clk);
    #1;
    chk_eq("t5_single_launch", 32'(txn_cnt - base_txn), 32'h1);
    chk_eq("t5_rsp_still_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    wait_drain();
    chk_eq("t5_both_launched", 32'(txn_cnt - base_txn), 32'h2);

    // Reset during WAIT_DONE with two commands queued.
    busy_len = 25;
    base_hs  = hs_cnt;
    push(2'd3, 2'b00, 2'b00, 32'h0000_0055);
    push(2'd1, 2'b00, 2'b00, 32'h0000_0066);
    push(2'd2, 2'b00, 2'b00, 32'h0000_0077);
    wait_busy(1'b1, "t6_busy_seen");
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk_eq("t6_reset_ctrl", 32'({cmd_ready, rsp_valid, txn_en, rsp_err}), 32'h8);
    chk_eq("t6_reset_fields", 32'({s_addr, txn_len, spi_mode, rsp_addr}), 32'h0);
    chk_eq("t6_reset_tx_data", tx_data_m, 32'h0);
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    wait_busy(1'b0, "t6_busy_release");
    @(posedge sys_clk);
    #1;
    chk_eq("t6_no_response", 32'(hs_cnt - base_hs), 32'h0);
    busy_len = 4;
    push(2'd0, 2'b01, 2'b01, 32'h0000_CAFE);
    @(posedge sys_clk);
    #1;
    chk_eq("t6_latency_txn_en", 32'(txn_en), 32'h1);
    wait_drain();
    chk_eq("t6_one_response", 32'(hs_cnt - base_hs), 32'h1);
    chk_eq("t6_rsp_data", last_data, 32'h90A4_0000);
    chk_eq("t6_rsp_err", 32'(last_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
